// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: sequential fetch, taken-branch redirect with a one-cycle flush, halt.
// Optional macro PC_SEQ_BR_STATS_EN enables the saturating taken-branch counter on taken_cnt.
module pc_sequencer #(
   parameter int unsigned                PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]        RESET_PC = '0,
   parameter int unsigned                PC_INC   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                halt,
   input  logic                br_valid,
   input  logic                isBranch,
   input  logic [PC_WIDTH-1:0] br_target,
   output logic [PC_WIDTH-1:0] pc,
   output logic                pc_valid,
   output logic                flush,
   output logic [1:0]          state_o,
   output logic [31:0]         taken_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      FLUSH = 2'b10,
      HALT  = 2'b11
   } state_t;

   localparam logic [PC_WIDTH-1:0] INC = PC_WIDTH'(PC_INC);

   state_t state;
   logic   take;

   // A branch is taken only from RUN when neither halt nor stall has priority.
   assign take    = (state == RUN) && !halt && !stall && br_valid && isBranch;
   assign state_o = state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         pc_valid <= 1'b0;
         flush    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state    <= RUN;
               pc_valid <= 1'b1;
               flush    <= 1'b0;
            end
            RUN: begin
               if (halt) begin
                  state    <= HALT;
                  pc_valid <= 1'b0;
                  flush    <= 1'b0;
               end else if (stall) begin
                  state    <= RUN;
               end else if (take) begin
                  state    <= FLUSH;
                  pc       <= br_target;
                  pc_valid <= 1'b0;
                  flush    <= 1'b1;
               end else begin
                  state    <= RUN;
                  pc       <= pc + INC;
                  pc_valid <= 1'b1;
                  flush    <= 1'b0;
               end
            end
            FLUSH: begin
               // The target is fetched now, so pc is not advanced on this edge.
               state    <= RUN;
               pc_valid <= 1'b1;
               flush    <= 1'b0;
            end
            default: begin
               state    <= HALT;
               pc_valid <= 1'b0;
               flush    <= 1'b0;
            end
         endcase
      end
   end

`ifdef PC_SEQ_BR_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         taken_cnt <= '0;
      end else if (take && (taken_cnt != 32'hFFFF_FFFF)) begin
         taken_cnt <= taken_cnt + 32'd1;
      end
   end
`else
   assign taken_cnt = '0;
`endif

endmodule
